// File: rtl/mic_alu_seq.sv
// mic_alu_seq: clocked execute-stage ALU with the zx/nx/zy/ny/f/no function set, iterative multiply and shifts
module mic_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             nv,
    output logic             zr,
    output logic             cy
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [1:0]         op;
    logic [WIDTH-1:0]   xr;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] pn;
    logic [SHW:0]       cnt;
    logic [SHW:0]       sh;
    logic [WIDTH-1:0]   xz;
    logic [WIDTH-1:0]   xa;
    logic [WIDTH-1:0]   yz;
    logic [WIDTH-1:0]   ya;
    logic [WIDTH-1:0]   lr;
    logic [WIDTH-1:0]   res0;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     mt;
    logic               c0;
    logic               cs;

    assign sh = {1'b0, y[SHW-1:0]};
    assign nv = out[WIDTH-1];
    assign zr = out == '0;

    // single-cycle logic/arith result for mode 0, computed from the live inputs at the accept edge
    always_comb begin
        xz   = zx ? '0 : x;
        xa   = nx ? ~xz : xz;
        yz   = zy ? '0 : y;
        ya   = ny ? ~yz : yz;
        sum  = {1'b0, xa} + {1'b0, ya};
        lr   = f ? sum[WIDTH-1:0] : (xa & ya);
        res0 = no ? ~lr : lr;
        c0   = f & sum[WIDTH];
    end

    // one iteration step: multiply keeps {partial_hi, multiplier_lo} and shifts right; shifts use the low half
    always_comb begin
        mt = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? xr : '0};
        pn = (op == 2'd1) ? {mt, p[WIDTH-1:1]}
           : (op == 2'd2) ? {p[2*WIDTH-1:WIDTH], p[WIDTH-2:0], 1'b0}
           :                {p[2*WIDTH-1:WIDTH], p[WIDTH-1], p[WIDTH-1:1]};
        cs = (op == 2'd2) ? p[WIDTH-1] : p[0];
    end

    // control FSM with registered result, flags and handshake; FIN is the done cycle and accepts like IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            cy    <= 1'b0;
        end else if (state == RUN) begin
            p   <= pn;
            cnt <= cnt - 1'b1;
            if (cnt == (SHW+1)'(1)) begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
                out   <= pn[WIDTH-1:0];
                cy    <= (op == 2'd1) ? |pn[2*WIDTH-1:WIDTH] : cs;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
            if (start) begin
                op <= mode;
                xr <= x;
                if (mode == 2'd0) begin
                    out   <= res0;
                    cy    <= c0;
                    done  <= 1'b1;
                    state <= FIN;
                end else if (mode == 2'd1) begin
                    p     <= {{WIDTH{1'b0}}, y};
                    cnt   <= (SHW+1)'(WIDTH);
                    busy  <= 1'b1;
                    state <= RUN;
                end else if (sh == '0) begin
                    out   <= x;
                    cy    <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end else begin
                    p     <= {{WIDTH{1'b0}}, x};
                    cnt   <= sh;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_alu_seq.sv
// tb_mic_alu_seq: table-driven, directed and randomized checks of mic_alu_seq at WIDTH 16, 8 and 32
module tb_mic_alu_seq;
    typedef struct {
        logic [1:0]  m;
        logic [5:0]  fb;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] eo;
        logic        ec;
        int          el;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [5:0]  fb = 6'd0;
    logic [15:0] x = 16'd0;
    logic [15:0] y = 16'd0;
    logic        busy, done, nv, zr, cy;
    logic [15:0] out;

    logic        start_p = 1'b0;
    logic [1:0]  mode_p = 2'd0;
    logic [5:0]  f_p = 6'd0;
    logic [31:0] xp = 32'd0;
    logic [31:0] yp = 32'd0;
    logic        b8, d8, n8, z8, c8;
    logic [7:0]  o8;
    logic        b32, d32, n32, z32, c32;
    logic [31:0] o32;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mic_alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .zx(fb[5]), .nx(fb[4]), .zy(fb[3]), .ny(fb[2]), .f(fb[1]), .no(fb[0]),
        .x(x), .y(y), .busy(busy), .done(done), .out(out), .nv(nv), .zr(zr), .cy(cy)
    );

    mic_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_p), .mode(mode_p),
        .zx(f_p[5]), .nx(f_p[4]), .zy(f_p[3]), .ny(f_p[2]), .f(f_p[1]), .no(f_p[0]),
        .x(xp[7:0]), .y(yp[7:0]), .busy(b8), .done(d8), .out(o8), .nv(n8), .zr(z8), .cy(c8)
    );

    mic_alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start_p), .mode(mode_p),
        .zx(f_p[5]), .nx(f_p[4]), .zy(f_p[3]), .ny(f_p[2]), .f(f_p[1]), .no(f_p[0]),
        .x(xp), .y(yp), .busy(b32), .done(d32), .out(o32), .nv(n32), .zr(z32), .cy(c32)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    // reference: plain arithmetic on 64-bit values, masked to w bits
    function automatic void model(input int w, input logic [1:0] m, input logic [5:0] f6,
                                  input logic [63:0] xi, input logic [63:0] yi,
                                  output logic [63:0] r, output logic c, output int lat);
        logic [63:0] mask, a, b, s;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a = xi & mask;
        b = yi & mask;
        c = 1'b0;
        lat = 1;
        r = a;
        if (m == 2'd0) begin
            if (f6[5]) a = 64'd0;
            if (f6[4]) a = ~a & mask;
            if (f6[3]) b = 64'd0;
            if (f6[2]) b = ~b & mask;
            s = f6[1] ? a + b : a & b;
            c = f6[1] & s[w];
            r = s & mask;
            if (f6[0]) r = ~r & mask;
        end else if (m == 2'd1) begin
            s = a * b;
            r = s & mask;
            c = (s >> w) != 64'd0;
            lat = w + 1;
        end else begin
            sh = int'(b % 64'(w));
            lat = sh + 1;
            if (sh != 0) begin
                if (m == 2'd2) begin
                    r = (a << sh) & mask;
                    c = a[w-sh];
                end else begin
                    s = a[w-1] ? (a | ~mask) : a;
                    r = 64'($signed(s) >>> sh) & mask;
                    c = a[sh-1];
                end
            end
        end
    endfunction

    task automatic do_op(input string nm, input logic [1:0] m, input logic [5:0] f6,
                         input logic [15:0] xi, input logic [15:0] yi,
                         input logic [15:0] eo, input logic ec, input int el);
        int k;
        int bc;
        @(negedge clk);
        mode = m; fb = f6; x = xi; y = yi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        bc = 0;
        while (!done && k < 80) begin
            bc += int'(busy);
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s latency", nm), 64'(k), 64'(el));
        chk($sformatf("%s busy_cycles", nm), 64'(bc), 64'(el - 1));
        chk($sformatf("%s busy_in_done", nm), 64'(busy), 64'd0);
        chk($sformatf("%s out", nm), 64'(out), 64'(eo));
        chk($sformatf("%s cy", nm), 64'(cy), 64'(ec));
        chk($sformatf("%s nv", nm), 64'(nv), 64'(eo[15]));
        chk($sformatf("%s zr", nm), 64'(zr), 64'(eo == 16'd0));
        @(negedge clk);
        chk($sformatf("%s done_one_cycle", nm), 64'(done), 64'd0);
    endtask

    task automatic run_param(input logic [1:0] m, input logic [5:0] f6,
                             input logic [31:0] xi, input logic [31:0] yi);
        logic [63:0] r8, r32;
        logic e8, e32;
        int l8, l32, g8, g32;
        model(8, m, f6, 64'(xi), 64'(yi), r8, e8, l8);
        model(32, m, f6, 64'(xi), 64'(yi), r32, e32, l32);
        @(negedge clk);
        mode_p = m; f_p = f6; xp = xi; yp = yi; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        g8 = 0;
        g32 = 0;
        for (int k = 1; k < 80 && (g8 == 0 || g32 == 0); k++) begin
            if (d8 && g8 == 0) begin
                g8 = k;
                chk($sformatf("w8 m%0d out", m), 64'(o8), r8);
                chk($sformatf("w8 m%0d cy", m), 64'(c8), 64'(e8));
            end
            if (d32 && g32 == 0) begin
                g32 = k;
                chk($sformatf("w32 m%0d out", m), 64'(o32), r32);
                chk($sformatf("w32 m%0d cy", m), 64'(c32), 64'(e32));
            end
            @(negedge clk);
        end
        chk($sformatf("w8 m%0d latency", m), 64'(g8), 64'(l8));
        chk($sformatf("w32 m%0d latency", m), 64'(g32), 64'(l32));
    endtask

    initial begin
        vec_t tbl[8];
        vec_t chain[4];
        logic [63:0] r;
        logic c;
        int l, k, nd;

        tbl[0] = '{2'd0, 6'b000010, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1};
        tbl[1] = '{2'd0, 6'b000010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1};
        tbl[2] = '{2'd0, 6'b110010, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1};
        tbl[3] = '{2'd1, 6'b000000, 16'd300,  16'd300,  16'h5F90, 1'b1, 17};
        tbl[4] = '{2'd1, 6'b111111, 16'd12,   16'd11,   16'd132,  1'b0, 17};
        tbl[5] = '{2'd3, 6'b000000, 16'h8004, 16'h0002, 16'hE001, 1'b0, 3};
        tbl[6] = '{2'd2, 6'b000000, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2};
        tbl[7] = '{2'd2, 6'b000000, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1};

        chain[0] = '{2'd3, 6'b000000, 16'h8004, 16'h0002, 16'hE001, 1'b0, 3};
        chain[1] = '{2'd0, 6'b000010, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1};
        chain[2] = '{2'd1, 6'b000000, 16'd12,   16'd11,   16'd132,  1'b0, 17};
        chain[3] = '{2'd2, 6'b000000, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out", 64'(out), 64'd0);
        chk("reset zr", 64'(zr), 64'd1);
        chk("reset nv", 64'(nv), 64'd0);
        chk("reset cy", 64'(cy), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        foreach (tbl[i])
            do_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].fb, tbl[i].x, tbl[i].y,
                  tbl[i].eo, tbl[i].ec, tbl[i].el);

        // abort a multiply with a two-cycle reset; no done may follow
        @(negedge clk);
        mode = 2'd1; x = 16'd3; y = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort out", 64'(out), 64'd0);
        chk("abort zr", 64'(zr), 64'd1);
        chk("abort nv", 64'(nv), 64'd0);
        chk("abort cy", 64'(cy), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        nd = 0;
        repeat (25) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort no_done", 64'(nd), 64'd0);

        // start held high: each op accepted in its predecessor's done cycle
        @(negedge clk);
        start = 1'b1;
        foreach (chain[i]) begin
            mode = chain[i].m; fb = chain[i].fb; x = chain[i].x; y = chain[i].y;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done && k < 80);
            chk($sformatf("chain%0d gap", i), 64'(k), 64'(chain[i].el));
            chk($sformatf("chain%0d out", i), 64'(out), 64'(chain[i].eo));
            chk($sformatf("chain%0d cy", i), 64'(cy), 64'(chain[i].ec));
        end
        start = 1'b0;
        @(negedge clk);
        chk("chain stop", 64'(done), 64'd0);

        // start pulsed while busy is ignored and not queued
        @(negedge clk);
        mode = 2'd1; fb = 6'd0; x = 16'd300; y = 16'd300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 80) begin
            if (k == 5) begin
                mode = 2'd0; fb = 6'b000010; x = 16'd1; y = 16'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("ignore latency", 64'(k), 64'd17);
        chk("ignore out", 64'(out), 64'h5F90);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("ignore no_queue", 64'(nd), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] m;
            logic [5:0] f6;
            logic [15:0] xi, yi;
            m = 2'($urandom_range(0, 3));
            f6 = 6'($urandom);
            xi = 16'($urandom);
            yi = 16'($urandom);
            model(16, m, f6, 64'(xi), 64'(yi), r, c, l);
            do_op($sformatf("rnd%0d", i), m, f6, xi, yi, r[15:0], c, l);
        end

        run_param(2'd0, 6'b000010, 32'd5, 32'd3);
        run_param(2'd0, 6'b000010, 32'hFFFFFFFF, 32'd1);
        run_param(2'd0, 6'b110010, 32'd7, 32'd0);
        run_param(2'd1, 6'b000000, 32'd300, 32'd300);
        run_param(2'd1, 6'b000000, 32'd12, 32'd11);
        run_param(2'd1, 6'b000000, 32'h12345678, 32'h00009ABC);
        for (int i = 0; i < 4; i++)
            run_param(2'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mic_alu_seq.md
Name: mic_alu_seq

Overview:
- Parametrised, clocked successor to the combinational 16-bit CPU ALU.
- Keeps the six-bit zx/nx/zy/ny/f/no function set.
- Adds iterative multiply, logical shift-left and arithmetic shift-right modes, a start/busy/done handshake, registered results and a carry/overflow flag.
- Sits in the CPU execute stage; the control unit stalls while busy is high.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from y[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- start  input  1  request; accepted only when busy=0
- mode  input  2  0=logic/arith, 1=multiply, 2=shift left logical, 3=shift right arithmetic
- zx,nx,zy,ny,f,no  input  1 each  function bits; used in mode 0 only
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B (in modes 2/3, y[SHW-1:0] is the shift amount)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- out  output  WIDTH  registered result
- nv  output  1  out[WIDTH-1]
- zr  output  1  out==0
- cy  output  1  carry / overflow / last bit shifted out

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- rst=1 at an edge:
  - out=0, nv=0, zr=1, cy=0, busy=0, done=0.
  - FSM returns to IDLE.
  - Any in-flight operation is aborted with no done.
- FSM states: IDLE, RUN, FIN.
- Accept: start=1 while busy=0 latches mode, function bits, x, y.
  - start while busy=1 is ignored; no queueing.
- Mode 0:
  - Compute in order: zero, negate, (f ? x+y : x&y), negate-out.
  - Result registered at the accept edge; done=1 the next cycle. Latency 1, busy never asserted.
  - cy = carry out of the WIDTH-bit add when f=1, before the no inversion; cy=0 when f=0.
- Mode 1, unsigned shift-add multiply:
  - Uses raw x, y; function bits ignored.
  - busy=1 for WIDTH cycles (RUN), one multiplier bit per cycle; then FIN drives done=1. Accept-to-done latency is WIDTH+1 cycles.
  - out = low WIDTH bits of x*y.
  - cy=1 iff the high WIDTH bits of the product are nonzero.
- Mode 2/3:
  - sh = y[SHW-1:0]. One bit per cycle for sh cycles in RUN with busy=1.
  - sh=0 skips RUN: latency 1, out=x, cy=0.
  - Latency is sh+1 cycles.
  - Mode 2 shifts in zeros. Mode 3 replicates x[WIDTH-1].
  - cy = last bit shifted out.
- done is high for exactly one cycle, in which busy=0.
  - A start in the done cycle is accepted, giving back-to-back operation.
- out/nv/zr/cy update only at the edge that raises done; they hold until the next done or reset.
- nv and zr are derived from the registered out and are always consistent with it.
- Arithmetic wraps modulo 2^WIDTH. There are no signed-overflow flags.

Test Plan:
- Reset: assert rst 2 cycles mid-multiply (x=3, y=5) -> out=0, zr=1, nv=0, cy=0, busy=0; no done pulse ever appears for the aborted op.
- Mode 0 with WIDTH=16:
  - x=0x0005, y=0x0003, f=1, other bits 0 -> one cycle later done=1, out=0x0008, cy=0.
  - x=0xFFFF, y=0x0001 -> out=0x0000, zr=1, cy=1.
  - zx=1,nx=1,zy=0,ny=0,f=1,no=0 (computes y-1) with y=0 -> out=0xFFFF, nv=1.
- Multiply, WIDTH=16:
  - x=300, y=300 -> busy high 16 cycles, done at cycle 17, out=0x5F90, cy=1.
  - x=12, y=11 -> out=132, cy=0.
- Shifts:
  - Mode 3, x=0x8004, y=2 -> latency 3, out=0xE001, cy=0, nv=1.
  - Mode 2, x=0x8001, y=1 -> out=0x0002, cy=1.
  - y=0 -> latency 1, out=x.
- Handshake:
  - start held high continuously -> ops issue back-to-back, each accepted in its predecessor's done cycle.
  - start pulsed while busy -> ignored; the original result is unchanged.
- Parametrisation: rerun the mode 0 and multiply cases at WIDTH=8 and WIDTH=32 -> results are correct modulo 2^WIDTH, and multiply latency is WIDTH+1.
